vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_timing_gen_if.sv | 53 +++++
 rtl/vga_axis_counter.sv | 30 +++
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 tb/tb_vga_timing_gen.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared defaults and the timing-config bundle for the VGA timing generator.
// The config struct is sized at CW_DEF; instances with CW <= CW_DEF fit in it.
package vga_pkg;

  localparam int CW_DEF = 12;
  localparam int FW_DEF = 16;

  typedef struct packed {
    logic [CW_DEF-1:0] hSyncStart;
    logic [CW_DEF-1:0] hBpStart;
    logic [CW_DEF-1:0] hVisStart;
    logic [CW_DEF-1:0] hEnd;
    logic [CW_DEF-1:0] vSyncStart;
    logic [CW_DEF-1:0] vBpStart;
    logic [CW_DEF-1:0] vVisStart;
    logic [CW_DEF-1:0] vEnd;
    logic              hPol;
    logic              vPol;
  } vga_cfg_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_axis_if: one axis counter's timing points in, count/decode out.
// vga_timing_gen_if: the generator's video/irq output bundle.
interface vga_axis_if
  import vga_pkg::*;
#(
  parameter int CW = CW_DEF
);
  logic          adv;
  logic [CW-1:0] syncStart;
  logic [CW-1:0] bpStart;
  logic [CW-1:0] visStart;
  logic [CW-1:0] endPt;
  logic [CW-1:0] cnt;
  logic          atEnd;
  logic          inSync;
  logic          inVis;

  modport master (
    output adv, syncStart, bpStart, visStart, endPt,
    input  cnt, atEnd, inSync, inVis
  );

  modport slave (
    input  adv, syncStart, bpStart, visStart, endPt,
    output cnt, atEnd, inSync, inVis
  );
endinterface

interface vga_timing_gen_if
  import vga_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int FW = FW_DEF
);
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          lineIrq;
  logic          frameIrq;
  logic [FW-1:0] frameCnt;

  modport master (
    output hsync, vsync, de, x, y,
    output lineIrq, frameIrq, frameCnt
  );

  modport slave (
    input hsync, vsync, de, x, y,
    input lineIrq, frameIrq, frameCnt
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: counts 0..endPt on each advance strobe, then wraps.
// Ports: i_clk, i_reset (sync, high), ax (slave): points in, cnt/decode out.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input logic     i_clk,
  input logic     i_reset,
  vga_axis_if.slave ax
);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ax.cnt <= '0;
    end else if (ax.adv) begin
      ax.cnt <= ax.atEnd ? '0 : ax.cnt + CW'(1);
    end
  end

  // A start >= stop window is empty, so degenerate sync needs no
  // special case; likewise visStart > endPt is never reached.
  always_comb begin
    ax.atEnd  = (ax.cnt == ax.endPt);
    ax.inSync = (ax.cnt >= ax.syncStart) &&
                (ax.cnt <  ax.bpStart);
    ax.inVis  = (ax.cnt >= ax.visStart);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator with shadowed config, line/frame irqs.
// Ports: i_clk, i_reset, i_ce, timing points/pols/irq line in; syncs, de, x/y, irqs, frame count out.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int FW = FW_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic [CW-1:0] i_h_sync_start,
  input  logic [CW-1:0] i_h_bp_start,
  input  logic [CW-1:0] i_h_vis_start,
  input  logic [CW-1:0] i_h_end,
  input  logic [CW-1:0] i_v_sync_start,
  input  logic [CW-1:0] i_v_bp_start,
  input  logic [CW-1:0] i_v_vis_start,
  input  logic [CW-1:0] i_v_end,
  input  logic          i_h_pol,
  input  logic          i_v_pol,
  input  logic [CW-1:0] i_irq_line,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_line_irq,
  output logic          o_frame_irq,
  output logic [FW-1:0] o_frame_cnt
);

  vga_cfg_t      cfgIn;
  vga_cfg_t      cfg;
  logic [CW-1:0] irqLine;
  logic          frameEnd;
  logic          lineHit;
  logic          deNext;

  vga_axis_if #(.CW(CW)) hAx ();
  vga_axis_if #(.CW(CW)) vAx ();

  always_comb begin
    cfgIn            = '0;
    cfgIn.hSyncStart = CW_DEF'(i_h_sync_start);
    cfgIn.hBpStart   = CW_DEF'(i_h_bp_start);
    cfgIn.hVisStart  = CW_DEF'(i_h_vis_start);
    cfgIn.hEnd       = CW_DEF'(i_h_end);
    cfgIn.vSyncStart = CW_DEF'(i_v_sync_start);
    cfgIn.vBpStart   = CW_DEF'(i_v_bp_start);
    cfgIn.vVisStart  = CW_DEF'(i_v_vis_start);
    cfgIn.vEnd       = CW_DEF'(i_v_end);
    cfgIn.hPol       = i_h_pol;
    cfgIn.vPol       = i_v_pol;
  end

  assign frameEnd = i_ce & hAx.atEnd & vAx.atEnd;
  assign lineHit  = i_ce & hAx.atEnd &
                    (vAx.cnt == irqLine);

  // Shadow reloads only on the last count of a frame, so the
  // counters wrap to (0,0) with the old bounds and the new
  // config governs the whole next frame.
  always_ff @(posedge i_clk) begin
    if (i_reset || frameEnd) begin
      cfg     <= cfgIn;
      irqLine <= i_irq_line;
    end
  end

  assign hAx.adv       = i_ce;
  assign hAx.syncStart = CW'(cfg.hSyncStart);
  assign hAx.bpStart   = CW'(cfg.hBpStart);
  assign hAx.visStart  = CW'(cfg.hVisStart);
  assign hAx.endPt     = CW'(cfg.hEnd);

  assign vAx.adv       = i_ce & hAx.atEnd;
  assign vAx.syncStart = CW'(cfg.vSyncStart);
  assign vAx.bpStart   = CW'(cfg.vBpStart);
  assign vAx.visStart  = CW'(cfg.vVisStart);
  assign vAx.endPt     = CW'(cfg.vEnd);

  vga_axis_counter #(.CW(CW)) uHCnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .ax      (hAx)
  );

  vga_axis_counter #(.CW(CW)) uVCnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .ax      (vAx)
  );

  assign deNext = hAx.inVis & vAx.inVis;

  // Irq pulses clear on every clock so they stay one clock wide
  // even when the following cycles have i_ce low.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_hsync     <= 1'b0;
      o_vsync     <= 1'b0;
      o_de        <= 1'b0;
      o_x         <= '0;
      o_y         <= '0;
      o_line_irq  <= 1'b0;
      o_frame_irq <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      o_line_irq  <= lineHit;
      o_frame_irq <= frameEnd;
      if (i_ce) begin
        o_hsync <= cfg.hPol ? hAx.inSync : ~hAx.inSync;
        o_vsync <= cfg.vPol ? vAx.inSync : ~vAx.inSync;
        o_de    <= deNext;
        o_x     <= deNext ? hAx.cnt - hAx.visStart : '0;
        o_y     <= deNext ? vAx.cnt - vAx.visStart : '0;
        if (frameEnd) begin
          o_frame_cnt <= o_frame_cnt + FW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen: per-clock model compare plus
// directed frame statistics against hand-derived constants.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int CW = 12;
  localparam int FW = 8;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          li;
    logic          fi;
    logic [FW-1:0] fc;
  } out_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic [CW-1:0] hss, hbp, hvs, hen;
  logic [CW-1:0] vss, vbp, vvs, ven;
  logic [CW-1:0] irq;
  logic          hpol, vpol;

  vga_timing_gen_if #(.CW(CW), .FW(FW)) vif ();

  vga_timing_gen #(.CW(CW), .FW(FW)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_ce           (ce),
    .i_h_sync_start (hss),
    .i_h_bp_start   (hbp),
    .i_h_vis_start  (hvs),
    .i_h_end        (hen),
    .i_v_sync_start (vss),
    .i_v_bp_start   (vbp),
    .i_v_vis_start  (vvs),
    .i_v_end        (ven),
    .i_h_pol        (hpol),
    .i_v_pol        (vpol),
    .i_irq_line     (irq),
    .o_hsync        (vif.hsync),
    .o_vsync        (vif.vsync),
    .o_de           (vif.de),
    .o_x            (vif.x),
    .o_y            (vif.y),
    .o_line_irq     (vif.lineIrq),
    .o_frame_irq    (vif.frameIrq),
    .o_frame_cnt    (vif.frameCnt)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  out_t          expQ[$];
  logic [CW-1:0] mh, mv, mIrq;
  vga_cfg_t      mc;
  out_t          mo;

  int tickNo, hsHi, vsHi, deCnt, xMax, yMax;
  int liCnt, coCnt;
  int fiPos[$];

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, act, exp);
    end
  endtask

  function automatic vga_cfg_t cfgNow();
    vga_cfg_t c;
    c = '{hss, hbp, hvs, hen, vss, vbp, vvs, ven,
          hpol, vpol};
    return c;
  endfunction

  function automatic out_t dutOut();
    out_t o;
    o.hs = vif.hsync;
    o.vs = vif.vsync;
    o.de = vif.de;
    o.x  = vif.x;
    o.y  = vif.y;
    o.li = vif.lineIrq;
    o.fi = vif.frameIrq;
    o.fc = vif.frameCnt;
    return o;
  endfunction

  // Reference model: expected outputs after the coming edge.
  task automatic modelStep();
    out_t n;
    logic hE, vE, hIn, vIn;
    if (rst) begin
      mh   = '0;
      mv   = '0;
      mc   = cfgNow();
      mIrq = irq;
      mo   = '0;
    end else begin
      n    = mo;
      n.li = 1'b0;
      n.fi = 1'b0;
      hE   = (mh == mc.hEnd);
      vE   = (mv == mc.vEnd);
      if (ce) begin
        hIn  = (mh >= mc.hSyncStart) && (mh < mc.hBpStart);
        vIn  = (mv >= mc.vSyncStart) && (mv < mc.vBpStart);
        n.hs = mc.hPol ? hIn : !hIn;
        n.vs = mc.vPol ? vIn : !vIn;
        n.de = (mh >= mc.hVisStart) && (mv >= mc.vVisStart);
        n.x  = n.de ? mh - mc.hVisStart : '0;
        n.y  = n.de ? mv - mc.vVisStart : '0;
        n.li = hE && (mv == mIrq);
        n.fi = hE && vE;
        if (n.fi) n.fc = mo.fc + 1'b1;
        if (hE) begin
          mh = '0;
          if (vE) begin
            mv   = '0;
            mc   = cfgNow();
            mIrq = irq;
          end else begin
            mv = mv + 1'b1;
          end
        end else begin
          mh = mh + 1'b1;
        end
      end
      mo = n;
    end
    expQ.push_back(mo);
  endtask

  task automatic clearStats();
    tickNo = 0; hsHi = 0; vsHi = 0; deCnt = 0;
    xMax = 0; yMax = 0; liCnt = 0; coCnt = 0;
    fiPos.delete();
  endtask

  task automatic tick();
    out_t got, exp;
    modelStep();
    @(posedge clk);
    #1;
    got = dutOut();
    if (expQ.size() == 0) begin
      chk("queue", 64'd0, 64'd1);
    end else begin
      exp = expQ.pop_front();
      chk("out", 64'(got), 64'(exp));
    end
    tickNo++;
    if (got.hs) hsHi++;
    if (got.vs) vsHi++;
    if (got.de) deCnt++;
    if (int'(got.x) > xMax) xMax = int'(got.x);
    if (int'(got.y) > yMax) yMax = int'(got.y);
    if (got.li) liCnt++;
    if (got.li && got.fi) coCnt++;
    if (got.fi) fiPos.push_back(tickNo);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic setCfg(input int he, input logic pol,
                        input int il);
    hss = 12'd2; hbp = 12'd4; hvs = 12'd6; hen = CW'(he);
    vss = 12'd1; vbp = 12'd2; vvs = 12'd3; ven = 12'd5;
    hpol = pol; vpol = pol; irq = CW'(il);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clearStats();
  endtask

  function automatic int fiAt(input int k);
    return (fiPos.size() > k) ? fiPos[k] : -1;
  endfunction

  initial begin
    ce = 1'b1;
    setCfg(9, 1'b1, 3);
    doReset();
    chk("rstHs", 64'(vif.hsync), 64'd0);
    chk("rstVs", 64'(vif.vsync), 64'd0);
    chk("rstDe", 64'(vif.de), 64'd0);
    chk("rstXY", 64'({vif.x, vif.y}), 64'd0);
    chk("rstIrq", 64'({vif.lineIrq, vif.frameIrq}), 64'd0);
    chk("rstFc", 64'(vif.frameCnt), 64'd0);

    run(120);
    chk("p1Hs", 64'(hsHi), 64'd24);
    chk("p1Vs", 64'(vsHi), 64'd20);
    chk("p1De", 64'(deCnt), 64'd24);
    chk("p1XMax", 64'(xMax), 64'd3);
    chk("p1YMax", 64'(yMax), 64'd2);
    chk("p1Li", 64'(liCnt), 64'd2);
    chk("p1Fi0", 64'(fiAt(0)), 64'd60);
    chk("p1Len", 64'(fiAt(1) - fiAt(0)), 64'd60);

    setCfg(9, 1'b0, 3);
    doReset();
    run(120);
    chk("p0Hs", 64'(hsHi), 64'd96);
    chk("p0Vs", 64'(vsHi), 64'd100);
    chk("p0De", 64'(deCnt), 64'd24);
    chk("p0Len", 64'(fiAt(1) - fiAt(0)), 64'd60);

    setCfg(9, 1'b1, 3);
    doReset();
    for (int i = 0; i < 240; i++) begin
      ce = (i % 2 == 0);
      tick();
    end
    ce = 1'b1;
    chk("ceDe", 64'(deCnt), 64'd48);
    chk("ceHs", 64'(hsHi), 64'd48);
    chk("ceLi", 64'(liCnt), 64'd2);
    chk("ceLen", 64'(fiAt(1) - fiAt(0)), 64'd120);

    setCfg(9, 1'b1, 5);
    doReset();
    run(60);
    chk("irq5Li", 64'(liCnt), 64'd1);
    chk("irq5Co", 64'(coCnt), 64'd1);

    setCfg(9, 1'b1, 7);
    doReset();
    run(60);
    chk("irq7Li", 64'(liCnt), 64'd0);
    chk("irq7Fi", 64'(fiPos.size()), 64'd1);

    setCfg(9, 1'b1, 3);
    doReset();
    run(20);
    hen = 12'd11;
    run(140);
    chk("chgFi0", 64'(fiAt(0)), 64'd60);
    chk("chgFi1", 64'(fiAt(1)), 64'd132);

    setCfg(9, 1'b1, 3);
    doReset();
    run(25);
    hen = 12'd7;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midHs", 64'(vif.hsync), 64'd0);
    chk("midDe", 64'(vif.de), 64'd0);
    chk("midXY", 64'({vif.x, vif.y}), 64'd0);
    chk("midIrq", 64'({vif.lineIrq, vif.frameIrq}), 64'd0);
    chk("midFc", 64'(vif.frameCnt), 64'd0);
    clearStats();
    run(50);
    chk("midFi0", 64'(fiAt(0)), 64'd48);

    setCfg(9, 1'b1, 3);
    doReset();
    run(255 * 60);
    chk("fc255", 64'(vif.frameCnt), 64'd255);
    run(60);
    chk("fcWrap", 64'(vif.frameCnt), 64'd0);
    chk("fcFrames", 64'(fiPos.size()), 64'd256);

    $display("Simulation finished: %0d checks, %0d errors",
             nChecks, nErrors);
    $finish;
  end

endmodule
